// File: rtl/commit_ctl.sv
// In-order commit controller: retires one ROB head entry per cycle and, on an
// exception, sequences flush, trap CSR update and front-end redirect.
module commit_ctl #(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 64,
    parameter int EXC_W   = 4,
    parameter int CNT_W   = 64,
    localparam int RegIdxLen = $clog2(REG_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rob_valid_i,
    output logic                 rob_ready_o,
    input  logic                 rob_rd_we_i,
    input  logic [RegIdxLen-1:0] rob_rd_idx_i,
    input  logic [XLEN-1:0]      rob_value_i,
    input  logic                 rob_except_i,
    input  logic [EXC_W-1:0]     rob_except_code_i,
    input  logic [XLEN-1:0]      rob_pc_i,
    input  logic [XLEN-1:0]      mtvec_i,
    output logic                 rf_we_o,
    output logic [RegIdxLen-1:0] rf_rd_idx_o,
    output logic [XLEN-1:0]      rf_value_o,
    output logic                 regstat_comm_valid_o,
    output logic [RegIdxLen-1:0] regstat_comm_rd_idx_o,
    output logic                 flush_o,
    output logic                 csr_exc_valid_o,
    output logic [XLEN-1:0]      csr_mepc_o,
    output logic [EXC_W-1:0]     csr_mcause_o,
    output logic                 fe_redirect_valid_o,
    output logic [XLEN-1:0]      fe_redirect_pc_o,
    input  logic                 fe_redirect_ready_i,
    output logic [CNT_W-1:0]     commit_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXCEPT   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_handshake;
    logic                   w_commit;
    logic                   w_trap;
    logic                   w_rf_write;

    logic                   r_rf_we;
    logic [RegIdxLen-1:0]   r_rf_rd_idx;
    logic [XLEN-1:0]        r_rf_value;
    logic                   r_regstat_valid;
    logic [RegIdxLen-1:0]   r_regstat_idx;
    logic                   r_flush;
    logic                   r_csr_exc_valid;
    logic [XLEN-1:0]        r_csr_mepc;
    logic [EXC_W-1:0]       r_csr_mcause;
    logic [XLEN-3:0]        r_mtvec_base;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic [CNT_W-1:0]       r_commit_cnt;

    assign rob_ready_o = (r_state == RUN);
    assign w_handshake = rob_valid_i && rob_ready_o;
    assign w_commit    = w_handshake && !rob_except_i;
    assign w_trap      = w_handshake && rob_except_i;
    // x0 is hardwired zero, so it never produces a write or a busy-counter decrement
    assign w_rf_write  = w_commit && rob_rd_we_i && (rob_rd_idx_i != '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_trap) w_state_next = EXCEPT;
            EXCEPT:   w_state_next = REDIRECT;
            REDIRECT: if (fe_redirect_ready_i) w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rf_we          <= 1'b0;
            r_rf_rd_idx      <= '0;
            r_rf_value       <= '0;
            r_regstat_valid  <= 1'b0;
            r_regstat_idx    <= '0;
            r_flush          <= 1'b0;
            r_csr_exc_valid  <= 1'b0;
            r_csr_mepc       <= '0;
            r_csr_mcause     <= '0;
            r_mtvec_base     <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_commit_cnt     <= '0;
        end else begin
            r_rf_we         <= w_rf_write;
            r_regstat_valid <= w_rf_write;
            if (w_rf_write) begin
                r_rf_rd_idx   <= rob_rd_idx_i;
                r_rf_value    <= rob_value_i;
                r_regstat_idx <= rob_rd_idx_i;
            end
            if (w_commit) begin
                r_commit_cnt <= r_commit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_trap) begin
                r_csr_mepc   <= rob_pc_i;
                r_csr_mcause <= rob_except_code_i;
                r_mtvec_base <= mtvec_i[XLEN-1:2];
            end
            // Flush and CSR strobes are high for exactly the EXCEPT cycle
            r_flush         <= (w_state_next == EXCEPT);
            r_csr_exc_valid <= (w_state_next == EXCEPT);
            r_redirect_valid <= (w_state_next == REDIRECT);
            if (r_state == EXCEPT) begin
                r_redirect_pc <= {r_mtvec_base, 2'b00};
            end
        end
    end

    assign rf_we_o               = r_rf_we;
    assign rf_rd_idx_o           = r_rf_rd_idx;
    assign rf_value_o            = r_rf_value;
    assign regstat_comm_valid_o  = r_regstat_valid;
    assign regstat_comm_rd_idx_o = r_regstat_idx;
    assign flush_o               = r_flush;
    assign csr_exc_valid_o       = r_csr_exc_valid;
    assign csr_mepc_o            = r_csr_mepc;
    assign csr_mcause_o          = r_csr_mcause;
    assign fe_redirect_valid_o   = r_redirect_valid;
    assign fe_redirect_pc_o      = r_redirect_pc;
    assign commit_cnt_o          = r_commit_cnt;

endmodule

// File: tb/tb_commit_ctl.sv
// Directed bench for commit_ctl: a default-width instance plus a CNT_W=4
// instance sharing the same stimulus, used to observe counter wraparound.
module tb_commit_ctl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rob_valid_i;
    logic        rob_rd_we_i;
    logic [4:0]  rob_rd_idx_i;
    logic [63:0] rob_value_i;
    logic        rob_except_i;
    logic [3:0]  rob_except_code_i;
    logic [63:0] rob_pc_i;
    logic [63:0] mtvec_i;
    logic        fe_redirect_ready_i;

    logic        rob_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_idx_o;
    logic [63:0] rf_value_o;
    logic        regstat_comm_valid_o;
    logic [4:0]  regstat_comm_rd_idx_o;
    logic        flush_o;
    logic        csr_exc_valid_o;
    logic [63:0] csr_mepc_o;
    logic [3:0]  csr_mcause_o;
    logic        fe_redirect_valid_o;
    logic [63:0] fe_redirect_pc_o;
    logic [63:0] commit_cnt_o;

    logic        s_rob_ready;
    logic        s_rf_we;
    logic [4:0]  s_rf_rd_idx;
    logic [63:0] s_rf_value;
    logic        s_regstat_valid;
    logic [4:0]  s_regstat_idx;
    logic        s_flush;
    logic        s_csr_exc_valid;
    logic [63:0] s_csr_mepc;
    logic [3:0]  s_csr_mcause;
    logic        s_redirect_valid;
    logic [63:0] s_redirect_pc;
    logic [3:0]  s_commit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    commit_ctl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rob_valid_i(rob_valid_i), .rob_ready_o(rob_ready_o),
        .rob_rd_we_i(rob_rd_we_i), .rob_rd_idx_i(rob_rd_idx_i),
        .rob_value_i(rob_value_i), .rob_except_i(rob_except_i),
        .rob_except_code_i(rob_except_code_i), .rob_pc_i(rob_pc_i),
        .mtvec_i(mtvec_i),
        .rf_we_o(rf_we_o), .rf_rd_idx_o(rf_rd_idx_o), .rf_value_o(rf_value_o),
        .regstat_comm_valid_o(regstat_comm_valid_o),
        .regstat_comm_rd_idx_o(regstat_comm_rd_idx_o),
        .flush_o(flush_o), .csr_exc_valid_o(csr_exc_valid_o),
        .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o),
        .fe_redirect_valid_o(fe_redirect_valid_o),
        .fe_redirect_pc_o(fe_redirect_pc_o),
        .fe_redirect_ready_i(fe_redirect_ready_i),
        .commit_cnt_o(commit_cnt_o)
    );

    commit_ctl #(.CNT_W(4)) dut_small (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rob_valid_i(rob_valid_i), .rob_ready_o(s_rob_ready),
        .rob_rd_we_i(rob_rd_we_i), .rob_rd_idx_i(rob_rd_idx_i),
        .rob_value_i(rob_value_i), .rob_except_i(rob_except_i),
        .rob_except_code_i(rob_except_code_i), .rob_pc_i(rob_pc_i),
        .mtvec_i(mtvec_i),
        .rf_we_o(s_rf_we), .rf_rd_idx_o(s_rf_rd_idx), .rf_value_o(s_rf_value),
        .regstat_comm_valid_o(s_regstat_valid),
        .regstat_comm_rd_idx_o(s_regstat_idx),
        .flush_o(s_flush), .csr_exc_valid_o(s_csr_exc_valid),
        .csr_mepc_o(s_csr_mepc), .csr_mcause_o(s_csr_mcause),
        .fe_redirect_valid_o(s_redirect_valid),
        .fe_redirect_pc_o(s_redirect_pc),
        .fe_redirect_ready_i(fe_redirect_ready_i),
        .commit_cnt_o(s_commit_cnt)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step(input string what);
        @(posedge clk_i);
        #1;
        $display("txn %-14s t=%0t ready=%0b rf_we=%0b rd=%0d flush=%0b redir=%0b cnt=%0d",
                 what, $time, rob_ready_o, rf_we_o, rf_rd_idx_o, flush_o,
                 fe_redirect_valid_o, commit_cnt_o);
    endtask

    task automatic set_commit(input logic we, input logic [4:0] rd, input logic [63:0] val);
        rob_valid_i  = 1'b1;
        rob_except_i = 1'b0;
        rob_rd_we_i  = we;
        rob_rd_idx_i = rd;
        rob_value_i  = val;
    endtask

    task automatic set_trap(input logic [63:0] pc, input logic [3:0] code, input logic [63:0] tvec);
        rob_valid_i       = 1'b1;
        rob_except_i      = 1'b1;
        rob_rd_we_i       = 1'b1;
        rob_rd_idx_i      = 5'd4;
        rob_pc_i          = pc;
        rob_except_code_i = code;
        mtvec_i           = tvec;
    endtask

    initial begin
        rst_ni = 1'b0;
        rob_valid_i = 1'b0; rob_rd_we_i = 1'b0; rob_rd_idx_i = '0; rob_value_i = '0;
        rob_except_i = 1'b0; rob_except_code_i = '0; rob_pc_i = '0; mtvec_i = '0;
        fe_redirect_ready_i = 1'b0;
        step("reset");
        step("reset");
        chk("rst_ready", rob_ready_o, 1'b1);
        chk("rst_outs", {rf_we_o, rf_rd_idx_o, rf_value_o, regstat_comm_valid_o,
                         regstat_comm_rd_idx_o, flush_o, csr_exc_valid_o, csr_mepc_o,
                         csr_mcause_o, fe_redirect_valid_o, fe_redirect_pc_o}, '0);
        chk("rst_cnt", commit_cnt_o, 64'd0);
        chk("rst_small", {s_rob_ready, s_rf_we, s_rf_rd_idx, s_rf_value, s_regstat_valid,
                          s_regstat_idx, s_flush, s_csr_exc_valid, s_csr_mepc, s_csr_mcause,
                          s_redirect_valid, s_redirect_pc, s_commit_cnt},
            {1'b1, 215'd0});
        rst_ni = 1'b1;

        set_commit(1'b1, 5'd5, 64'hDEAD);
        step("commit_rd5");
        chk("c5_we", {rf_we_o, regstat_comm_valid_o}, 2'b11);
        chk("c5_idx", {rf_rd_idx_o, regstat_comm_rd_idx_o}, {5'd5, 5'd5});
        chk("c5_val", rf_value_o, 64'hDEAD);
        chk("c5_cnt", commit_cnt_o, 64'd1);

        set_commit(1'b1, 5'd0, 64'h11);
        step("commit_x0");
        chk("x0_we", {rf_we_o, regstat_comm_valid_o, rob_ready_o}, 3'b001);
        chk("x0_cnt", commit_cnt_o, 64'd2);
        set_commit(1'b0, 5'd3, 64'h33);
        step("commit_nowe");
        chk("nowe_we", {rf_we_o, regstat_comm_valid_o, rob_ready_o}, 3'b001);
        chk("nowe_cnt", commit_cnt_o, 64'd3);
        set_commit(1'b1, 5'd7, 64'h77);
        step("commit_rd7");
        chk("c7", {rf_we_o, regstat_comm_valid_o, rf_rd_idx_o, rf_value_o, rob_ready_o},
            {2'b11, 5'd7, 64'h77, 1'b1});
        chk("c7_cnt", commit_cnt_o, 64'd4);
        set_commit(1'b1, 5'd31, 64'h3131);
        step("commit_rd31");
        chk("c31", {rf_we_o, regstat_comm_valid_o, regstat_comm_rd_idx_o, rf_value_o, rob_ready_o},
            {2'b11, 5'd31, 64'h3131, 1'b1});
        chk("c31_cnt", commit_cnt_o, 64'd5);

        set_trap(64'h1000, 4'd2, 64'h8000_0003);
        step("trap_except");
        chk("ex_strobes", {flush_o, csr_exc_valid_o, fe_redirect_valid_o, rob_ready_o}, 4'b1100);
        chk("ex_mepc", csr_mepc_o, 64'h1000);
        chk("ex_mcause", csr_mcause_o, 4'd2);
        chk("ex_nowrite", {rf_we_o, regstat_comm_valid_o}, 2'b00);
        chk("ex_cnt", commit_cnt_o, 64'd5);
        // ROB keeps offering a commit that must be ignored while not ready
        set_commit(1'b1, 5'd6, 64'h66);
        for (int i = 0; i < 5; i++) begin
            step("redirect_hold");
            chk("hold_strobes", {fe_redirect_valid_o, flush_o, csr_exc_valid_o, rob_ready_o,
                                 rf_we_o, regstat_comm_valid_o}, 6'b100000);
            chk("hold_pc", fe_redirect_pc_o, 64'h8000_0000);
            chk("hold_cnt", commit_cnt_o, 64'd5);
        end
        fe_redirect_ready_i = 1'b1;
        rob_valid_i = 1'b0;
        step("redirect_acc");
        chk("acc_run", {rob_ready_o, fe_redirect_valid_o, rf_we_o}, 3'b100);
        fe_redirect_ready_i = 1'b1;

        set_commit(1'b1, 5'd9, 64'h99);
        step("commit_rd9");
        chk("c9", {rf_we_o, rf_rd_idx_o, rf_value_o, flush_o}, {1'b1, 5'd9, 64'h99, 1'b0});
        chk("c9_cnt", commit_cnt_o, 64'd6);
        set_trap(64'h2000, 4'd5, 64'h4000);
        step("trap_after_c9");
        chk("t2_strobes", {flush_o, rf_we_o, regstat_comm_valid_o}, 3'b100);
        chk("t2_csr", {csr_mepc_o, csr_mcause_o}, {64'h2000, 4'd5});
        chk("t2_cnt", commit_cnt_o, 64'd6);
        rob_valid_i = 1'b0; rob_except_i = 1'b0;
        step("redirect_imm");
        chk("t2_redir", {fe_redirect_valid_o, rob_ready_o, flush_o}, 3'b100);
        chk("t2_pc", fe_redirect_pc_o, 64'h4000);
        step("back_to_run");
        chk("t2_run", {rob_ready_o, fe_redirect_valid_o}, 2'b10);
        fe_redirect_ready_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_commit(1'b0, 5'd1, 64'h0);
            step("commit_fill");
        end
        chk("pre_wrap", s_commit_cnt, 4'd15);
        step("commit_wrap");
        chk("wrap_small", s_commit_cnt, 4'd0);
        chk("wrap_main", commit_cnt_o, 64'd16);

        set_trap(64'h3000, 4'd7, 64'hC000);
        step("trap3_except");
        rob_valid_i = 1'b0; rob_except_i = 1'b0;
        step("trap3_redirect");
        chk("t3_redir", {fe_redirect_valid_o, rob_ready_o}, 2'b10);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_ready", rob_ready_o, 1'b1);
        chk("arst_outs", {rf_we_o, regstat_comm_valid_o, flush_o, csr_exc_valid_o,
                          fe_redirect_valid_o, fe_redirect_pc_o, csr_mepc_o, commit_cnt_o},
            '0);
        step("in_reset");
        rst_ni = 1'b1;
        set_commit(1'b1, 5'd2, 64'h22);
        step("post_reset");
        chk("pr_commit", {rf_we_o, rf_rd_idx_o, commit_cnt_o}, {1'b1, 5'd2, 64'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
